// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit : N-port bypass select, load-use and multi-cycle
// scoreboard hazard detection beside the EX stage.            Rev 1.0
// ============================================================================
module hazard_scoreboard_unit #(
  parameter int NUM_READ_PORTS = 3,
  parameter int NUM_FWD_STAGES = 2,
  parameter int NUM_REGS       = 32,
  parameter int MAX_LAT        = 7,
  parameter int STALL_CNT_W    = 32,
  localparam int REG_AW        = $clog2(NUM_REGS),
  localparam int CNT_W         = $clog2(MAX_LAT + 1),
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_READ_PORTS*REG_AW-1:0] ex_rs_addr_i,
  input  logic [NUM_READ_PORTS-1:0]        ex_rs_used_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_reg_write_i,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd_addr_i,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_data_valid_i,
  input  logic                             issue_valid_i,
  input  logic [REG_AW-1:0]                issue_rd_i,
  input  logic [CNT_W-1:0]                 issue_lat_i,
  input  logic                             flush_i,
  output logic [NUM_READ_PORTS*SEL_W-1:0]  fwd_sel_o,
  output logic                             stall_o,
  output logic                             busy_o,
  output logic [STALL_CNT_W-1:0]           stall_cycles_o
);

  localparam int NUM_SLOTS = 1 << REG_AW;
  localparam logic [CNT_W-1:0] LAT_CAP = CNT_W'(MAX_LAT);

  logic [NUM_SLOTS*CNT_W-1:0]   cnt_flat;
  logic [NUM_READ_PORTS-1:0]    port_lu;
  logic [NUM_READ_PORTS-1:0]    port_raw;
  logic                         waw;
  logic                         issue_fire;
  logic                         load_en;
  logic [CNT_W-1:0]             lat_clamped;
  logic [STALL_CNT_W-1:0]       stall_cycles_q;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    logic [REG_AW-1:0] rs_addr;
    logic [SEL_W-1:0]  win;
    logic              win_valid;
    logic              active;

    assign rs_addr = ex_rs_addr_i[p*REG_AW +: REG_AW];
    assign active  = ex_rs_used_i[p] && (rs_addr != '0);

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
      win       = '0;
      win_valid = 1'b1;
      for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
        if (fwd_reg_write_i[k-1] && (fwd_rd_addr_i[(k-1)*REG_AW +: REG_AW] == rs_addr)) begin
          win       = SEL_W'(k);
          win_valid = fwd_data_valid_i[k-1];
        end
      end
    end

    assign fwd_sel_o[p*SEL_W +: SEL_W] = active ? win : '0;
    assign port_lu[p]  = active && (win != '0) && !win_valid;
    assign port_raw[p] = active && (cnt_flat[rs_addr*CNT_W +: CNT_W] != '0);
  end

  assign waw         = issue_valid_i && (cnt_flat[issue_rd_i*CNT_W +: CNT_W] != '0);
  assign stall_o     = (|port_lu) || (|port_raw) || waw;
  assign issue_fire  = issue_valid_i && !stall_o && !flush_i;
  assign lat_clamped = (issue_lat_i > LAT_CAP) ? LAT_CAP : issue_lat_i;
  assign load_en     = issue_fire && (issue_rd_i != '0) && (issue_lat_i != '0);

  for (genvar r = 0; r < NUM_SLOTS; r++) begin : g_cnt
    if (r == 0 || r >= NUM_REGS) begin : g_zero
      assign cnt_flat[r*CNT_W +: CNT_W] = '0;
    end else begin : g_live
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
          cnt_d = '0;
        end else if (load_en && (issue_rd_i == REG_AW'(r))) begin
          cnt_d = lat_clamped;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign cnt_flat[r*CNT_W +: CNT_W] = cnt_q;
    end
  end

  assign busy_o = |cnt_flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall_o && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_unit : directed + random stimulus against a
// behavioural hazard model.                                   Rev 1.0
// ============================================================================
module tb_hazard_scoreboard_unit;

  localparam int NP   = 3;
  localparam int NF   = 2;
  localparam int NR   = 32;
  localparam int ML   = 5;
  localparam int SW   = 6;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int SELW = 2;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]      rs_addr [NP];
  logic [NP-1:0]      rs_used;
  logic [NF-1:0]      fwe;
  logic [NF-1:0]      fdv;
  logic [AW-1:0]      frd [NF];
  logic               iv;
  logic [AW-1:0]      ird;
  logic [CW-1:0]      ilat;
  logic               fl;

  logic [NP*AW-1:0]   rs_addr_p;
  logic [NF*AW-1:0]   frd_p;
  logic [NP*SELW-1:0] fwd_sel;
  logic               stall;
  logic               busy;
  logic [SW-1:0]      stall_cycles;

  always_comb begin
    for (int p = 0; p < NP; p++) rs_addr_p[p*AW +: AW] = rs_addr[p];
    for (int k = 0; k < NF; k++) frd_p[k*AW +: AW] = frd[k];
  end

  hazard_scoreboard_unit #(
    .NUM_READ_PORTS(NP), .NUM_FWD_STAGES(NF), .NUM_REGS(NR),
    .MAX_LAT(ML), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rs_addr_i(rs_addr_p), .ex_rs_used_i(rs_used),
    .fwd_reg_write_i(fwe), .fwd_rd_addr_i(frd_p), .fwd_data_valid_i(fdv),
    .issue_valid_i(iv), .issue_rd_i(ird), .issue_lat_i(ilat), .flush_i(fl),
    .fwd_sel_o(fwd_sel), .stall_o(stall), .busy_o(busy),
    .stall_cycles_o(stall_cycles)
  );

  // Reference model: outstanding cycles per register plus a stall tally.
  int m_cnt [NR];
  int m_sc;
  int e_sel [NP];
  bit e_stall;
  bit e_busy;
  bit m_fire;

  always_comb begin
    e_stall = 1'b0;
    e_busy  = 1'b0;
    for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) e_busy = 1'b1;
    for (int p = 0; p < NP; p++) begin
      e_sel[p] = 0;
      if (rs_used[p] && rs_addr[p] != 0) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= NF; k++) begin
          if (!found && fwe[k-1] && frd[k-1] == rs_addr[p]) begin
            found    = 1'b1;
            e_sel[p] = k;
            if (!fdv[k-1]) e_stall = 1'b1;
          end
        end
        if (m_cnt[rs_addr[p]] != 0) e_stall = 1'b1;
      end
    end
    if (iv && m_cnt[ird] != 0) e_stall = 1'b1;
    m_fire = iv && !e_stall && !fl;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) m_cnt[r] <= 0;
      m_sc <= 0;
    end else begin
      if (e_stall && m_sc < SMAX) m_sc <= m_sc + 1;
      for (int r = 0; r < NR; r++) begin
        if (fl)
          m_cnt[r] <= 0;
        else if (m_fire && r != 0 && int'(ird) == r && ilat != 0)
          m_cnt[r] <= (int'(ilat) > ML) ? ML : int'(ilat);
        else if (m_cnt[r] > 0)
          m_cnt[r] <= m_cnt[r] - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++)
        chk($sformatf("model_sel%0d", p), fwd_sel[p*SELW +: SELW], e_sel[p]);
      chk("model_stall", stall, e_stall);
      chk("model_busy", busy, e_busy);
      chk("model_stall_cycles", stall_cycles, m_sc);
    end
  end

  task automatic idle();
    for (int p = 0; p < NP; p++) rs_addr[p] = '0;
    for (int k = 0; k < NF; k++) frd[k] = '0;
    rs_used = '0; fwe = '0; fdv = '0;
    iv = 1'b0; ird = '0; ilat = '0; fl = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input int rd, input int lat);
    iv = 1'b1; ird = AW'(rd); ilat = CW'(lat);
  endtask

  task automatic read0(input int rd);
    rs_used[0] = 1'b1; rs_addr[0] = AW'(rd);
  endtask

  initial begin
    idle();
    #12;
    chk("reset_sel", fwd_sel, 0);
    chk("reset_stall", stall, 0);
    chk("reset_busy", busy, 0);
    chk("reset_stall_cycles", stall_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Forwarding priority
    nxt(); read0(5); fwe = 2'b11; fdv = 2'b11; frd[0] = 5; frd[1] = 5; settle();
    chk("fwd_youngest", fwd_sel[1:0], 1);
    chk("fwd_youngest_stall", stall, 0);
    nxt(); read0(5); fwe = 2'b11; fdv = 2'b11; frd[0] = 6; frd[1] = 5; settle();
    chk("fwd_older", fwd_sel[1:0], 2);

    nxt(); rs_used[1] = 1'b1; rs_addr[1] = 0; fwe = 2'b11; fdv = 2'b11; settle();
    chk("x0_sel", fwd_sel[3:2], 0);
    chk("x0_stall", stall, 0);

    // Load-use
    nxt(); rs_used[2] = 1'b1; rs_addr[2] = 7; fwe = 2'b11; fdv = 2'b10;
    frd[0] = 7; frd[1] = 7; settle();
    chk("loaduse_stall", stall, 1);
    nxt(); rs_used[2] = 1'b1; rs_addr[2] = 7; fwe = 2'b11; fdv = 2'b11;
    frd[0] = 7; frd[1] = 7; settle();
    chk("loaduse_release", stall, 0);
    chk("loaduse_sel", fwd_sel[5:4], 1);
    chk("loaduse_count", stall_cycles, 1);

    // RAW on a multi-cycle result
    nxt(); issue(9, 3); settle();
    chk("raw_issue_stall", stall, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); read0(9); settle();
      chk($sformatf("raw_stall_t%0d", i), stall, (i <= 3) ? 1 : 0);
      if (i == 3) chk("raw_busy_t3", busy, 1);
      if (i == 4) chk("raw_busy_t4", busy, 0);
    end

    // WAW re-issue
    nxt(); issue(9, 5); settle();
    nxt(); settle();
    for (int i = 2; i <= 6; i++) begin
      nxt(); issue(9, 2); settle();
      chk($sformatf("waw_stall_t%0d", i), stall, (i <= 5) ? 1 : 0);
    end
    nxt(); settle();
    chk("waw_accepted_busy", busy, 1);
    nxt(); settle();
    nxt(); settle();
    chk("waw_drained", busy, 0);

    // Latency clamp to MAX_LAT
    nxt(); issue(10, 7); settle();
    for (int i = 1; i <= 6; i++) begin
      nxt(); read0(10); settle();
      if (i == 1) chk("clamp_model_cnt", m_cnt[10], ML);
      if (i == 5) chk("clamp_stall_t5", stall, 1);
      if (i == 6) chk("clamp_stall_t6", stall, 0);
    end

    // Flush beats a simultaneous issue
    nxt(); issue(3, 4); settle();
    nxt(); settle();
    nxt(); fl = 1'b1; issue(4, 3); settle();
    chk("flush_busy_before", busy, 1);
    nxt(); read0(4); settle();
    chk("flush_busy_after", busy, 0);
    chk("flush_no_x4", stall, 0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      nxt();
      for (int p = 0; p < NP; p++) rs_addr[p] = AW'($urandom_range(0, 7));
      for (int k = 0; k < NF; k++) frd[k] = AW'($urandom_range(0, 7));
      rs_used = NP'($urandom);
      fwe = NF'($urandom);
      for (int k = 0; k < NF; k++) fdv[k] = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 2) == 0);
      ird = AW'($urandom_range(0, 7));
      ilat = CW'($urandom);
      fl = ($urandom_range(0, 24) == 0);
    end

    // Saturation of the stall counter
    for (int c = 0; c < 70; c++) begin
      nxt(); rs_used[2] = 1'b1; rs_addr[2] = 7; fwe = 2'b01; fdv = 2'b00; frd[0] = 7;
    end
    settle();
    chk("sat_stall_cycles", stall_cycles, SMAX);
    nxt(); settle();
    chk("sat_hold", stall_cycles, SMAX);

    // Asynchronous reset mid-operation
    for (int c = 0; c < 8; c++) nxt();
    issue(5, 5);
    nxt(); settle();
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", busy, 0);
    chk("midop_reset_count", stall_cycles, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    nxt(); read0(5); settle();
    chk("midop_no_entry", stall, 0);
    nxt();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
